// File: rtl/branch_predict_unit.sv
`default_nettype none
// ============================================================================
// Module      : branch_predict_unit
// Description : Branch resolution and direction prediction for the 16-bit
//               pipeline. The fetch stage reads a table of 2-bit saturating
//               counters. The MEM stage resolves branches against the ALU
//               flags and trains the table. It issues a registered
//               redirect/flush on a mispredict and keeps hit/miss statistics.
// Revision    : 1.0 - initial release
// ============================================================================
module branch_predict_unit #(
    parameter int ADDR_W    = 8,
    parameter int BHT_DEPTH = 16,
    parameter int CNT_W     = 16,
    parameter int PRED_EN   = 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [ADDR_W-1:0] if_pc,
    output logic              if_pred_taken,
    input  logic              mem_valid,
    input  logic [15:0]       mem_ir,
    input  logic [ADDR_W-1:0] mem_pc,
    input  logic              mem_pred_taken,
    input  logic [ADDR_W-1:0] mem_target,
    input  logic              zf,
    input  logic              nf,
    input  logic              cf,
    output logic              jump,
    output logic              flush,
    output logic [ADDR_W-1:0] redirect_addr,
    output logic [CNT_W-1:0]  br_cnt,
    output logic [CNT_W-1:0]  miss_cnt
);

    localparam int IDX_W = (BHT_DEPTH > 1) ? $clog2(BHT_DEPTH) : 1;

    // Branch opcodes (mem_ir[15:11])
    localparam logic [4:0] c_OP_BZ   = 5'h10;
    localparam logic [4:0] c_OP_BNZ  = 5'h11;
    localparam logic [4:0] c_OP_BN   = 5'h12;
    localparam logic [4:0] c_OP_BNN  = 5'h13;
    localparam logic [4:0] c_OP_BC   = 5'h14;
    localparam logic [4:0] c_OP_BNC  = 5'h15;
    localparam logic [4:0] c_OP_JMPR = 5'h16;

    // Per-entry direction state; the MSB is the predicted direction
    typedef enum logic [1:0] {
        SN = 2'b00,
        WN = 2'b01,
        WT = 2'b10,
        ST = 2'b11
    } bht_state_t;

    bht_state_t              bht_q [BHT_DEPTH];
    bht_state_t              bht_cur;
    bht_state_t              bht_d;
    logic                    bht_we;
    logic [IDX_W-1:0]        wr_idx;
    logic [IDX_W-1:0]        rd_idx;

    logic [4:0]              opcode;
    logic                    is_cond;
    logic                    is_jmpr;
    logic                    cond_true;
    logic                    resolve;
    logic                    taken;
    logic                    mispredict;

    logic                    jump_q,  jump_d;
    logic                    flush_q, flush_d;
    logic                    shadow_q, shadow_d;
    logic [ADDR_W-1:0]       redirect_q, redirect_d;
    logic [CNT_W-1:0]        br_cnt_q, br_cnt_d;
    logic [CNT_W-1:0]        miss_cnt_q, miss_cnt_d;

    // Only the opcode field and the index bits of the fetch PC matter here
    logic                    unused_bits;
    assign unused_bits = &{1'b0, mem_ir[10:0], if_pc};

    assign opcode = mem_ir[15:11];
    assign wr_idx = mem_pc[IDX_W-1:0];
    assign rd_idx = if_pc[IDX_W-1:0];

    // Decode branch class and evaluate its condition against the flags
    always_comb begin
        is_cond   = 1'b0;
        is_jmpr   = 1'b0;
        cond_true = 1'b0;
        case (opcode)
            c_OP_BZ:   begin is_cond = 1'b1; cond_true = zf;  end
            c_OP_BNZ:  begin is_cond = 1'b1; cond_true = ~zf; end
            c_OP_BN:   begin is_cond = 1'b1; cond_true = nf;  end
            c_OP_BNN:  begin is_cond = 1'b1; cond_true = ~nf; end
            c_OP_BC:   begin is_cond = 1'b1; cond_true = cf;  end
            c_OP_BNC:  begin is_cond = 1'b1; cond_true = ~cf; end
            c_OP_JMPR: begin is_jmpr = 1'b1; end
            default:   ;
        endcase
    end

    // The shadow blocks the instruction that sits in MEM while a flush is out
    assign resolve    = mem_valid & (is_cond | is_jmpr) & ~shadow_q;
    assign taken      = is_jmpr | cond_true;
    assign mispredict = resolve & (taken != mem_pred_taken);

    // Saturating counter step for the entry addressed by the MEM PC
    always_comb begin
        bht_cur = bht_q[wr_idx];
        bht_d   = bht_cur;
        bht_we  = (PRED_EN != 0) & resolve & is_cond;
        case (bht_cur)
            SN:      bht_d = taken ? WN : SN;
            WN:      bht_d = taken ? WT : SN;
            WT:      bht_d = taken ? ST : WN;
            ST:      bht_d = taken ? ST : WT;
            default: bht_d = WN;
        endcase
    end

    // Next-state for the registered pipeline controls and statistics
    always_comb begin
        jump_d     = resolve & taken;
        flush_d    = mispredict;
        shadow_d   = mispredict;
        redirect_d = redirect_q;
        br_cnt_d   = br_cnt_q;
        miss_cnt_d = miss_cnt_q;
        if (resolve) begin
            redirect_d = taken ? mem_target : (mem_pc + ADDR_W'(1));
            if (br_cnt_q != {CNT_W{1'b1}}) begin
                br_cnt_d = br_cnt_q + CNT_W'(1);
            end
        end
        if (mispredict && (miss_cnt_q != {CNT_W{1'b1}})) begin
            miss_cnt_d = miss_cnt_q + CNT_W'(1);
        end
    end

    // Control/statistics registers; reset wins over any pending resolve
    always_ff @(posedge clock) begin
        if (reset) begin
            jump_q     <= 1'b0;
            flush_q    <= 1'b0;
            shadow_q   <= 1'b0;
            redirect_q <= '0;
            br_cnt_q   <= '0;
            miss_cnt_q <= '0;
        end else begin
            jump_q     <= jump_d;
            flush_q    <= flush_d;
            shadow_q   <= shadow_d;
            redirect_q <= redirect_d;
            br_cnt_q   <= br_cnt_d;
            miss_cnt_q <= miss_cnt_d;
        end
    end

    // Direction table: all entries weakly not-taken after reset
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < BHT_DEPTH; i++) begin
                bht_q[i] <= WN;
            end
        end else if (bht_we) begin
            bht_q[wr_idx] <= bht_d;
        end
    end

    // Fetch lookup reads stored state, so a same-cycle update is not visible
    generate
        if (PRED_EN != 0) begin : g_pred_bht
            assign if_pred_taken = bht_q[rd_idx][1];
        end else begin : g_pred_static
            assign if_pred_taken = 1'b0;
        end
    endgenerate

    assign jump          = jump_q;
    assign flush         = flush_q;
    assign redirect_addr = redirect_q;
    assign br_cnt        = br_cnt_q;
    assign miss_cnt      = miss_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_branch_predict_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_branch_predict_unit
// Description : Directed bench for branch_predict_unit. A reference model
//               pushes expected outputs to a scoreboard as each MEM-stage
//               instruction is driven; they are popped and compared one
//               cycle later. A second instance with 2-bit statistics
//               counters shares the stimulus to exercise saturation.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_branch_predict_unit;

    localparam logic [4:0] c_OP_NOP  = 5'h00;
    localparam logic [4:0] c_OP_BZ   = 5'h10;
    localparam logic [4:0] c_OP_BNZ  = 5'h11;
    localparam logic [4:0] c_OP_BN   = 5'h12;
    localparam logic [4:0] c_OP_BNN  = 5'h13;
    localparam logic [4:0] c_OP_BC   = 5'h14;
    localparam logic [4:0] c_OP_BNC  = 5'h15;
    localparam logic [4:0] c_OP_JMPR = 5'h16;

    logic        clock = 1'b0;
    logic        reset;
    logic [7:0]  if_pc;
    logic        mem_valid;
    logic [15:0] mem_ir;
    logic [7:0]  mem_pc;
    logic        mem_pred_taken;
    logic [7:0]  mem_target;
    logic        zf, nf, cf;

    logic        if_pred_taken, jump, flush;
    logic [7:0]  redirect_addr;
    logic [15:0] br_cnt, miss_cnt;

    logic        if_pred_taken2, jump2, flush2;
    logic [7:0]  redirect_addr2;
    logic [1:0]  br_cnt2, miss_cnt2;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string      tag;
        logic       jump;
        logic       flush;
        logic [7:0] redir;
        logic [15:0] br;
        logic [15:0] miss;
        logic [1:0] br2;
        logic [1:0] miss2;
    } exp_t;

    exp_t sb[$];

    // Reference model state
    logic [1:0]  m_bht [16];
    logic        m_shadow;
    logic [7:0]  m_redir;
    logic [15:0] m_br, m_miss;
    logic [1:0]  m_br2, m_miss2;

    always #5 clock = ~clock;

    branch_predict_unit #(
        .ADDR_W(8), .BHT_DEPTH(16), .CNT_W(16), .PRED_EN(1)
    ) dut (
        .clock(clock), .reset(reset), .if_pc(if_pc), .if_pred_taken(if_pred_taken),
        .mem_valid(mem_valid), .mem_ir(mem_ir), .mem_pc(mem_pc),
        .mem_pred_taken(mem_pred_taken), .mem_target(mem_target),
        .zf(zf), .nf(nf), .cf(cf), .jump(jump), .flush(flush),
        .redirect_addr(redirect_addr), .br_cnt(br_cnt), .miss_cnt(miss_cnt)
    );

    branch_predict_unit #(
        .ADDR_W(8), .BHT_DEPTH(16), .CNT_W(2), .PRED_EN(1)
    ) dut2 (
        .clock(clock), .reset(reset), .if_pc(if_pc), .if_pred_taken(if_pred_taken2),
        .mem_valid(mem_valid), .mem_ir(mem_ir), .mem_pc(mem_pc),
        .mem_pred_taken(mem_pred_taken), .mem_target(mem_target),
        .zf(zf), .nf(nf), .cf(cf), .jump(jump2), .flush(flush2),
        .redirect_addr(redirect_addr2), .br_cnt(br_cnt2), .miss_cnt(miss_cnt2)
    );

    // Watchdog: the sequence is fixed-length, so this only fires on a hang
    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not reach the summary");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic pop_check();
        exp_t e;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL scoreboard: observed empty queue expected one entry");
        end else begin
            e = sb.pop_front();
            chk({e.tag, ".jump"},     {31'd0, jump},          {31'd0, e.jump});
            chk({e.tag, ".flush"},    {31'd0, flush},         {31'd0, e.flush});
            chk({e.tag, ".redirect"}, {24'd0, redirect_addr}, {24'd0, e.redir});
            chk({e.tag, ".br_cnt"},   {16'd0, br_cnt},        {16'd0, e.br});
            chk({e.tag, ".miss_cnt"}, {16'd0, miss_cnt},      {16'd0, e.miss});
            chk({e.tag, ".br_cnt2"},  {30'd0, br_cnt2},       {30'd0, e.br2});
            chk({e.tag, ".miss_cnt2"},{30'd0, miss_cnt2},     {30'd0, e.miss2});
        end
    endtask

    // Combinational lookup check against the model table
    task automatic check_pred(input string tag, input logic [7:0] pc);
        if_pc = pc;
        #1;
        chk({tag, ".pred"}, {31'd0, if_pred_taken}, {31'd0, m_bht[pc[3:0]][1]});
    endtask

    // Drive one MEM-stage slot (called just after a falling edge)
    task automatic step(input string tag, input logic valid, input logic [4:0] op,
                        input logic [7:0] pc, input logic pred, input logic [7:0] tgt,
                        input logic z, input logic n, input logic c);
        exp_t e;
        logic is_cond, is_j, cond, res, tk, mis;
        mem_valid = valid; mem_ir = {op, 11'd0}; mem_pc = pc;
        mem_pred_taken = pred; mem_target = tgt; zf = z; nf = n; cf = c;
        is_cond = (op >= c_OP_BZ) && (op <= c_OP_BNC);
        is_j    = (op == c_OP_JMPR);
        case (op)
            c_OP_BZ:  cond = z;
            c_OP_BNZ: cond = !z;
            c_OP_BN:  cond = n;
            c_OP_BNN: cond = !n;
            c_OP_BC:  cond = c;
            c_OP_BNC: cond = !c;
            default:  cond = 1'b0;
        endcase
        res = valid && (is_cond || is_j) && !m_shadow;
        tk  = is_j || cond;
        mis = res && (tk != pred);
        if (res) begin
            m_redir = tk ? tgt : pc + 8'd1;
            if (m_br != 16'hFFFF) m_br = m_br + 16'd1;
            if (m_br2 != 2'd3)    m_br2 = m_br2 + 2'd1;
            if (is_cond) begin
                if (tk && m_bht[pc[3:0]] != 2'd3)  m_bht[pc[3:0]] = m_bht[pc[3:0]] + 2'd1;
                if (!tk && m_bht[pc[3:0]] != 2'd0) m_bht[pc[3:0]] = m_bht[pc[3:0]] - 2'd1;
            end
        end
        if (mis) begin
            if (m_miss != 16'hFFFF) m_miss = m_miss + 16'd1;
            if (m_miss2 != 2'd3)    m_miss2 = m_miss2 + 2'd1;
        end
        m_shadow = mis;
        e.tag = tag; e.jump = res && tk; e.flush = mis; e.redir = m_redir;
        e.br = m_br; e.miss = m_miss; e.br2 = m_br2; e.miss2 = m_miss2;
        sb.push_back(e);
        @(posedge clock);
        @(negedge clock);
        pop_check();
    endtask

    task automatic idle(input string tag);
        step(tag, 1'b0, c_OP_NOP, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    endtask

    // Reset for one cycle while leaving whatever is on the MEM inputs
    task automatic do_reset(input string tag);
        exp_t e;
        reset = 1'b1;
        for (int i = 0; i < 16; i++) m_bht[i] = 2'b01;
        m_shadow = 1'b0; m_redir = 8'h00;
        m_br = 16'd0; m_miss = 16'd0; m_br2 = 2'd0; m_miss2 = 2'd0;
        e.tag = tag; e.jump = 1'b0; e.flush = 1'b0; e.redir = 8'h00;
        e.br = 16'd0; e.miss = 16'd0; e.br2 = 2'd0; e.miss2 = 2'd0;
        sb.push_back(e);
        @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        pop_check();
    endtask

    initial begin
        reset = 1'b1; if_pc = 8'h00; mem_valid = 1'b0; mem_ir = 16'h0000;
        mem_pc = 8'h00; mem_pred_taken = 1'b0; mem_target = 8'h00;
        zf = 1'b0; nf = 1'b0; cf = 1'b0;
        @(negedge clock);
        do_reset("reset");
        check_pred("rst_pc00", 8'h00);
        check_pred("rst_pc5A", 8'h5A);
        check_pred("rst_pcFF", 8'hFF);

        // Taken BZ predicted not-taken: flush to target, entry 0 WN->WT
        step("bz_miss", 1'b1, c_OP_BZ, 8'h10, 1'b0, 8'h40, 1'b1, 1'b0, 1'b0);
        check_pred("bz_train_pc20", 8'h20);
        idle("idle1");

        // Not-taken BNC at 0xFF: redirect wraps to 0x00, entry 15 01->00
        step("bnc_miss1", 1'b1, c_OP_BNC, 8'hFF, 1'b1, 8'h33, 1'b0, 1'b0, 1'b1);
        idle("idle2");
        step("bnc_miss2", 1'b1, c_OP_BNC, 8'hFF, 1'b1, 8'h33, 1'b0, 1'b0, 1'b1);
        check_pred("bnc_sat_pc0F", 8'h0F);
        idle("idle3");
        // One taken step from a saturated 00 must land on 01 (still not-taken)
        step("bnc_taken", 1'b1, c_OP_BNC, 8'hFF, 1'b0, 8'h33, 1'b0, 1'b0, 1'b0);
        check_pred("bnc_after_sat", 8'hFF);
        idle("idle4");

        // Shadow: BZ right behind a mispredicting BN is dropped entirely
        step("bn_miss", 1'b1, c_OP_BN, 8'h22, 1'b0, 8'h50, 1'b0, 1'b1, 1'b0);
        step("bz_shadow", 1'b1, c_OP_BZ, 8'h22, 1'b0, 8'h60, 1'b1, 1'b0, 1'b0);
        step("bz_nt", 1'b1, c_OP_BZ, 8'h22, 1'b1, 8'h60, 1'b0, 1'b0, 1'b0);
        check_pred("shadow_bht_pc02", 8'h02);
        idle("idle5");

        // JMPR: always taken, never trains
        step("jmpr_hit", 1'b1, c_OP_JMPR, 8'h31, 1'b1, 8'h77, 1'b0, 1'b0, 1'b0);
        check_pred("jmpr_no_train", 8'h31);
        step("jmpr_miss", 1'b1, c_OP_JMPR, 8'h31, 1'b0, 8'h88, 1'b0, 1'b0, 1'b0);
        idle("idle6");

        // Fresh start: five correct back-to-back branches saturate the 2-bit count
        do_reset("reset2");
        for (int i = 0; i < 5; i++) begin
            step($sformatf("bz_hit%0d", i), 1'b1, c_OP_BZ, 8'h40, 1'b0, 8'h90,
                 1'b0, 1'b0, 1'b0);
        end
        step("bz_tk1", 1'b1, c_OP_BZ, 8'h40, 1'b0, 8'h90, 1'b1, 1'b0, 1'b0);
        idle("idle7");
        step("bz_tk2", 1'b1, c_OP_BZ, 8'h40, 1'b0, 8'h90, 1'b1, 1'b0, 1'b0);
        idle("idle8");
        check_pred("pre_reset_pc40", 8'h40);

        // Reset with a mispredicting branch sitting in MEM
        mem_valid = 1'b1; mem_ir = {c_OP_BZ, 11'd0}; mem_pc = 8'h40;
        mem_pred_taken = 1'b0; mem_target = 8'h99; zf = 1'b1; nf = 1'b0; cf = 1'b0;
        do_reset("reset_miss");
        check_pred("post_reset_pc40", 8'h40);
        idle("idle9");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
